mips_instr_encoder: RTL and testbench

Inverse of the single-cycle CPU's control-unit decode. It accepts symbolic instruction beats (operation select plus register, shift, immediate and target fields) over a valid/ready handshake. Each beat is encoded into a 32-bit MIPS word and written to consecutive instruction-memory addresses. Used as the program loader ahead of the single-cycle core, on the instruction-memory write port.

---
 rtl/mips_instr_encoder.sv | 127 ++++++++++++
 tb/tb_mips_instr_encoder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes symbolic instruction beats into 32-bit MIPS words and
// writes them to consecutive instruction-memory addresses starting at BASE.
module mips_instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opsel,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              illegal
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(2**ADDR_W);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pointer;
  logic              finishing;
  logic              accept;
  logic              enc_legal;
  logic [31:0]       enc_word;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_opsel)
      5'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
      5'd1:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
      5'd2:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
      5'd3:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
      5'd4:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100110};
      5'd5:    enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000000};
      5'd6:    enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000010};
      5'd7:    enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_sa, 6'b000011};
      5'd8:    enc_word = {6'b000000, in_rs, 15'd0, 6'b001000};
      5'd9:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
      5'd10:   enc_word = {6'b001100, in_rs, in_rt, in_imm};
      5'd11:   enc_word = {6'b001101, in_rs, in_rt, in_imm};
      5'd12:   enc_word = {6'b001110, in_rs, in_rt, in_imm};
      5'd13:   enc_word = {6'b100011, in_rs, in_rt, in_imm};
      5'd14:   enc_word = {6'b101011, in_rs, in_rt, in_imm};
      5'd15:   enc_word = {6'b000100, in_rs, in_rt, in_imm};
      5'd16:   enc_word = {6'b000101, in_rs, in_rt, in_imm};
      5'd17:   enc_word = {6'b001111, 5'd0, in_rt, in_imm};
      5'd18:   enc_word = {6'b000010, in_target};
      5'd19:   enc_word = {6'b000011, in_target};
      default: enc_legal = 1'b0;
    endcase
  end

  // The in-flight write counts against capacity so the last slot is never oversubscribed.
  assign in_ready = (state == LOAD) && !finishing &&
                    ((word_count + (ADDR_W+1)'(imem_we)) < DEPTH_W);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == LOAD) || imem_we;
  assign done     = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        if (imem_we && (word_count + (ADDR_W+1)'(1)) == DEPTH_W)
          state_next = DONE;
        else if ((finish || finishing) && !(accept && enc_legal))
          state_next = DONE;
      end
      DONE: if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pointer    <= BASE_ADDR;
      word_count <= '0;
      illegal    <= 1'b0;
      finishing  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
    end else begin
      imem_we <= accept && enc_legal;
      // A write committing this edge advances the pointer, so the new beat lands one past it.
      if (accept && enc_legal) begin
        imem_addr  <= pointer + ADDR_W'(imem_we);
        imem_wdata <= enc_word;
      end
      if (imem_we) begin
        pointer    <= pointer + ADDR_W'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
      end
      if (accept && !enc_legal) illegal <= 1'b1;
      if (state == LOAD && finish) finishing <= 1'b1;
      if (start && state != LOAD) begin
        pointer    <= BASE_ADDR;
        word_count <= '0;
        illegal    <= 1'b0;
        finishing  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: encoding table, full/wrap, illegal,
// finish-with-beat and reset-after-accept sequences.
module tb_mips_instr_encoder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start, finish, in_valid;
  logic [4:0]  opsel, rs, rt, rd, sa;
  logic [15:0] imm;
  logic [25:0] target;

  logic        ready0, we0, busy0, done0, ill0;
  logic [7:0]  addr0;
  logic [31:0] wdata0;
  logic [8:0]  wc0;
  logic        ready1, we1, busy1, done1, ill1;
  logic [1:0]  addr1;
  logic [31:0] wdata1;
  logic [2:0]  wc1;
  logic        ready2, we2, busy2, done2, ill2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  wc2;

  mips_instr_encoder #(.ADDR_W(8), .BASE(0)) dut (
    .clock(clock), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(ready0), .in_opsel(opsel), .in_rs(rs),
    .in_rt(rt), .in_rd(rd), .in_sa(sa), .in_imm(imm), .in_target(target),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0), .busy(busy0),
    .done(done0), .word_count(wc0), .illegal(ill0));

  mips_instr_encoder #(.ADDR_W(2), .BASE(0)) dut_small (
    .clock(clock), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(ready1), .in_opsel(opsel), .in_rs(rs),
    .in_rt(rt), .in_rd(rd), .in_sa(sa), .in_imm(imm), .in_target(target),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1), .busy(busy1),
    .done(done1), .word_count(wc1), .illegal(ill1));

  mips_instr_encoder #(.ADDR_W(2), .BASE(3)) dut_wrap (
    .clock(clock), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(ready2), .in_opsel(opsel), .in_rs(rs),
    .in_rt(rt), .in_rd(rd), .in_sa(sa), .in_imm(imm), .in_target(target),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2), .busy(busy2),
    .done(done2), .word_count(wc2), .illegal(ill2));

  typedef struct {
    logic [4:0]  opsel, rs, rt, rd, sa;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[20];

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  logic [31:0] q0_data[$];
  logic [7:0]  q0_addr[$];
  int          q0_cyc[$];
  logic [1:0]  q1_addr[$];
  logic [1:0]  q2_addr[$];

  always @(posedge clock) cycle <= cycle + 1;

  always @(negedge clock) begin
    if (we0) begin
      q0_data.push_back(wdata0);
      q0_addr.push_back(addr0);
      q0_cyc.push_back(cycle);
    end
    if (we1) q1_addr.push_back(addr1);
    if (we2) q2_addr.push_back(addr2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input vec_t v);
    opsel = v.opsel; rs = v.rs; rt = v.rt; rd = v.rd; sa = v.sa;
    imm = v.imm; target = v.target;
  endtask

  task automatic send(input vec_t v);
    int n;
    drive(v);
    in_valid = 1'b1;
    n = 0;
    while (!ready0 && n < 20) begin
      tick();
      n++;
    end
    if (!ready0) check("send_ready_timeout", 32'(ready0), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_session();
    int n;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    n = 0;
    while (!done0 && n < 50) begin
      tick();
      n++;
    end
    check("done_reached", 32'(done0), 32'd1);
  endtask

  task automatic clear_queues();
    q0_data.delete(); q0_addr.delete(); q0_cyc.delete();
    q1_addr.delete(); q2_addr.delete();
  endtask

  initial begin
    vec_t v;
    logic [5:0] rdy_seen, done_seen;
    int accepts;

    vecs[0]  = '{5'd0,  5'd1,  5'd2,  5'd3,  5'd7,  16'hFFFF, 26'h3FFFFFF, 32'h00221820};
    vecs[1]  = '{5'd1,  5'd4,  5'd5,  5'd6,  5'd1,  16'hFFFF, 26'h3FFFFFF, 32'h00853022};
    vecs[2]  = '{5'd2,  5'd7,  5'd8,  5'd9,  5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h00E84824};
    vecs[3]  = '{5'd3,  5'd10, 5'd11, 5'd12, 5'd5,  16'hFFFF, 26'h3FFFFFF, 32'h014B6025};
    vecs[4]  = '{5'd4,  5'd13, 5'd14, 5'd15, 5'd9,  16'hFFFF, 26'h3FFFFFF, 32'h01AE7826};
    vecs[5]  = '{5'd5,  5'd9,  5'd5,  5'd4,  5'd2,  16'hFFFF, 26'h3FFFFFF, 32'h00052080};
    vecs[6]  = '{5'd6,  5'd1,  5'd16, 5'd17, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h00108FC2};
    vecs[7]  = '{5'd7,  5'd31, 5'd18, 5'd19, 5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h001298C3};
    vecs[8]  = '{5'd8,  5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h03E00008};
    vecs[9]  = '{5'd9,  5'd1,  5'd2,  5'd31, 5'd31, 16'h8000, 26'h3FFFFFF, 32'h20228000};
    vecs[10] = '{5'd10, 5'd3,  5'd4,  5'd31, 5'd31, 16'h00FF, 26'h3FFFFFF, 32'h306400FF};
    vecs[11] = '{5'd11, 5'd5,  5'd6,  5'd31, 5'd31, 16'h1234, 26'h3FFFFFF, 32'h34A61234};
    vecs[12] = '{5'd12, 5'd7,  5'd8,  5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h38E8FFFF};
    vecs[13] = '{5'd13, 5'd1,  5'd2,  5'd31, 5'd31, 16'h0004, 26'h3FFFFFF, 32'h8C220004};
    vecs[14] = '{5'd14, 5'd1,  5'd2,  5'd31, 5'd31, 16'h0008, 26'h3FFFFFF, 32'hAC220008};
    vecs[15] = '{5'd15, 5'd9,  5'd10, 5'd31, 5'd31, 16'hFFFE, 26'h3FFFFFF, 32'h112AFFFE};
    vecs[16] = '{5'd16, 5'd11, 5'd12, 5'd31, 5'd31, 16'h0003, 26'h3FFFFFF, 32'h156C0003};
    vecs[17] = '{5'd17, 5'd7,  5'd1,  5'd31, 5'd31, 16'hABCD, 26'h3FFFFFF, 32'h3C01ABCD};
    vecs[18] = '{5'd18, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h0BFFFFFF};
    vecs[19] = '{5'd19, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010, 32'h0C000010};

    reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    drive(vecs[0]);
    tick();
    tick();
    check("rst_ready", 32'(ready0), 32'd0);
    check("rst_we",    32'(we0),    32'd0);
    check("rst_busy",  32'(busy0),  32'd0);
    check("rst_done",  32'(done0),  32'd0);
    check("rst_illegal", 32'(ill0), 32'd0);
    check("rst_addr",  32'(addr0),  32'd0);
    check("rst_wdata", wdata0,      32'd0);
    check("rst_count", 32'(wc0),    32'd0);
    check("rst_addr_base3", 32'(addr2), 32'd3);
    reset = 1'b0;
    tick();

    // Every opsel encoding, back-to-back in one session.
    clear_queues();
    pulse_start();
    for (int i = 0; i < 20; i++) send(vecs[i]);
    end_session();
    check("table_writes", 32'(q0_data.size()), 32'd20);
    for (int i = 0; i < 20 && i < q0_data.size(); i++) begin
      check($sformatf("enc_op%0d", vecs[i].opsel), q0_data[i], vecs[i].word);
      check($sformatf("addr_%0d", i), 32'(q0_addr[i]), 32'(i));
      check($sformatf("rate_%0d", i), 32'(q0_cyc[i] - q0_cyc[0]), 32'(i));
    end
    check("table_count", 32'(wc0), 32'd20);
    check("table_busy",  32'(busy0), 32'd0);
    check("table_we",    32'(we0), 32'd0);

    // Fill a 4-deep memory with in_valid held high.
    clear_queues();
    pulse_start();
    drive(vecs[0]);
    in_valid = 1'b1;
    accepts = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 6) begin
        rdy_seen[k]  = ready1;
        done_seen[k] = done1;
      end
      if (ready1) accepts++;
      tick();
    end
    in_valid = 1'b0;
    check("full_ready_seq", 32'(rdy_seen),  32'b001111);
    check("full_done_seq",  32'(done_seen), 32'b100000);
    check("full_accepts",   32'(accepts),   32'd4);
    check("full_writes",    32'(q1_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < q1_addr.size(); i++)
      check($sformatf("full_addr_%0d", i), 32'(q1_addr[i]), 32'(i));
    check("wrap_writes", 32'(q2_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < q2_addr.size(); i++)
      check($sformatf("wrap_addr_%0d", i), 32'(q2_addr[i]), 32'((i + 3) % 4));
    check("full_count",  32'(wc1), 32'd4);
    check("wrap_count",  32'(wc2), 32'd4);
    check("full_done",   32'(done1), 32'd1);
    check("full_ready0", 32'(ready1), 32'd0);
    end_session();

    // Illegal opsel between two legal beats.
    clear_queues();
    pulse_start();
    send(vecs[0]);
    v = vecs[1];
    v.opsel = 5'd25;
    send(v);
    send(vecs[3]);
    check("illegal_set", 32'(ill0), 32'd1);
    end_session();
    check("illegal_writes", 32'(q0_data.size()), 32'd2);
    if (q0_data.size() == 2) begin
      check("illegal_w0", q0_data[0], vecs[0].word);
      check("illegal_w1", q0_data[1], vecs[3].word);
      check("illegal_a1", 32'(q0_addr[1]), 32'd1);
    end
    check("illegal_count", 32'(wc0), 32'd2);
    check("illegal_sticky", 32'(ill0), 32'd1);
    pulse_start();
    check("illegal_cleared", 32'(ill0), 32'd0);
    check("restart_count", 32'(wc0), 32'd0);
    check("restart_busy",  32'(busy0), 32'd1);

    // finish in the same cycle as an accepted beat.
    clear_queues();
    drive(vecs[13]);
    in_valid = 1'b1;
    finish = 1'b1;
    check("fin_ready_before", 32'(ready0), 32'd1);
    tick();
    finish = 1'b0;
    drive(vecs[14]);
    check("fin_ready_after", 32'(ready0), 32'd0);
    check("fin_we",    32'(we0), 32'd1);
    check("fin_addr",  32'(addr0), 32'd0);
    check("fin_wdata", wdata0, 32'h8C220004);
    tick();
    in_valid = 1'b0;
    check("fin_done",  32'(done0), 32'd1);
    check("fin_we_off", 32'(we0), 32'd0);
    check("fin_count", 32'(wc0), 32'd1);
    check("fin_writes", 32'(q0_data.size()), 32'd1);

    // Reset the cycle after an accept drops the pending write.
    pulse_start();
    send(vecs[0]);
    check("pre_rst_we", 32'(we0), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_we",    32'(we0),    32'd0);
    check("mid_rst_ready", 32'(ready0), 32'd0);
    check("mid_rst_busy",  32'(busy0),  32'd0);
    check("mid_rst_done",  32'(done0),  32'd0);
    check("mid_rst_ill",   32'(ill0),   32'd0);
    check("mid_rst_addr",  32'(addr0),  32'd0);
    check("mid_rst_wdata", wdata0,      32'd0);
    check("mid_rst_count", 32'(wc0),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
